// File: rtl/bcd3_seg_scan.sv
// Three-digit BCD display driver: captures digits on a strobe and scans them onto a
// multiplexed seven-segment display with leading-zero blanking, blink and error flag.
module bcd3_seg_scan #(
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned BLINK_DIV  = 50000000,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       load,
    input  logic       blank_lz,
    input  logic       blink_en,
    output logic [7:0] seg,
    output logic [2:0] an,
    output logic       err
);

    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [7:0] SEG_INV = {8{ACTIVE_LOW}};
    localparam logic [2:0] AN_INV = {3{ACTIVE_LOW}};

    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          blink_ph_q, blink_ph_d;
    logic [3:0]    sh_h_q, sh_h_d;
    logic [3:0]    sh_t_q, sh_t_d;
    logic [3:0]    sh_o_q, sh_o_d;
    logic          err_q, err_d;
    logic [7:0]    seg_q, seg_d;
    logic [2:0]    an_q, an_d;

    logic [3:0] cur_digit;
    logic [2:0] cur_an;
    logic       blanked;
    logic       dark;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            case (idx_q)
                2'd0:    idx_d = 2'd1;
                2'd1:    idx_d = 2'd2;
                default: idx_d = 2'd0;
            endcase
        end else if (idx_q == 2'd3) begin
            idx_d = 2'd0;
        end

        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_ph_d  = blink_ph_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
        end
    end

    always_comb begin
        sh_h_d = sh_h_q;
        sh_t_d = sh_t_q;
        sh_o_d = sh_o_q;
        err_d  = err_q;
        if (load) begin
            sh_h_d = hundreds;
            sh_t_d = tens;
            sh_o_d = ones;
            err_d  = (hundreds > 4'd9) || (tens > 4'd9) || (ones > 4'd9);
        end
    end

    // Output stage works from pre-edge index and shadow; index 3 is shown as the ones slot.
    always_comb begin
        case (idx_q)
            2'd1: begin
                cur_digit = sh_t_q;
                cur_an    = 3'b010;
                blanked   = blank_lz && (sh_h_q == 4'd0) && (sh_t_q == 4'd0);
            end
            2'd2: begin
                cur_digit = sh_h_q;
                cur_an    = 3'b100;
                blanked   = blank_lz && (sh_h_q == 4'd0);
            end
            default: begin
                cur_digit = sh_o_q;
                cur_an    = 3'b001;
                blanked   = 1'b0;
            end
        endcase
        dark = blink_en && blink_ph_q;

        if (blanked || dark) begin
            seg_d = SEG_INV;
            an_d  = AN_INV;
        end else begin
            seg_d = {1'b0, seg_decode(cur_digit)} ^ SEG_INV;
            an_d  = cur_an ^ AN_INV;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q  <= '0;
            idx_q       <= 2'd0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            sh_h_q      <= 4'd0;
            sh_t_q      <= 4'd0;
            sh_o_q      <= 4'd0;
            err_q       <= 1'b0;
            seg_q       <= SEG_INV;
            an_q        <= AN_INV;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            sh_h_q      <= sh_h_d;
            sh_t_q      <= sh_t_d;
            sh_o_q      <= sh_o_d;
            err_q       <= err_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign err = err_q;

endmodule

// File: tb/tb_bcd3_seg_scan.sv
// Bench for bcd3_seg_scan: two instances (active-high and active-low pins) checked every
// cycle against a time-based reference model of the display.
module tb_bcd3_seg_scan;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] hundreds = 4'd0;
    logic [3:0] tens = 4'd0;
    logic [3:0] ones = 4'd0;
    logic       load = 1'b0;
    logic       blank_lz = 1'b0;
    logic       blink_en = 1'b0;
    logic [7:0] seg, seg_al;
    logic [2:0] an, an_al;
    logic       err, err_al;

    int checks = 0;
    int errors = 0;

    // Reference model: edges since reset, captured digits, expected pins.
    int         k = 0;
    logic [3:0] m_h = 0, m_t = 0, m_o = 0;
    logic       m_err = 0;
    logic [7:0] e_seg = 0;
    logic [2:0] e_an = 0;
    logic [6:0] font [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F};

    bcd3_seg_scan #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .hundreds(hundreds), .tens(tens), .ones(ones), .load(load),
        .blank_lz(blank_lz), .blink_en(blink_en), .seg(seg), .an(an), .err(err)
    );

    bcd3_seg_scan #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst(rst), .hundreds(hundreds), .tens(tens), .ones(ones), .load(load),
        .blank_lz(blank_lz), .blink_en(blink_en), .seg(seg_al), .an(an_al), .err(err_al)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        if (d > 4'd9) return 7'h40;
        return font[d];
    endfunction

    // One clock edge; model evaluates which slot is being shown by elapsed time alone.
    task automatic tick();
        int         slot;
        int         phase;
        logic [3:0] d;
        logic       hide;
        @(posedge clk);
        if (rst) begin
            k = 0; m_h = 0; m_t = 0; m_o = 0; m_err = 0; e_seg = 0; e_an = 0;
        end else begin
            slot  = (k / SCAN_DIV) % 3;
            phase = (k / BLINK_DIV) % 2;
            d     = (slot == 0) ? m_o : (slot == 1) ? m_t : m_h;
            hide  = (blink_en && phase == 1)
                 || (blank_lz && slot == 2 && m_h == 0)
                 || (blank_lz && slot == 1 && m_h == 0 && m_t == 0);
            e_seg = hide ? 8'h00 : {1'b0, glyph(d)};
            e_an  = hide ? 3'b000 : 3'(1 << slot);
            if (load) begin
                m_h = hundreds; m_t = tens; m_o = ones;
                m_err = (hundreds > 9) || (tens > 9) || (ones > 9);
            end
            k++;
        end
        #1;
    endtask

    task automatic do_load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        hundreds = h; tens = t; ones = o; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (seg !== 8'h00 || an !== 3'b000 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_hi: got seg=%h an=%b err=%b want 00 000 0", seg, an, err);
        end
        checks++;
        if (seg_al !== 8'hFF || an_al !== 3'b111 || err_al !== 1'b0) begin
            errors++;
            $display("FAIL reset_lo: got seg=%h an=%b err=%b want FF 111 0",
                     seg_al, an_al, err_al);
        end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        int lit_seen [3];
        lit_seen = '{0, 0, 0};
        blank_lz = 1'b0; blink_en = 1'b0;
        do_load(4'd1, 4'd2, 4'd3);
        for (int i = 0; i < 3 * SCAN_DIV * 3; i++) begin
            tick();
            checks++;
            if (seg !== e_seg || an !== e_an || err !== m_err) begin
                errors++;
                $display("FAIL scan[%0d]: got seg=%h an=%b err=%b want %h %b %b",
                         i, seg, an, err, e_seg, e_an, m_err);
            end
            checks++;
            if (seg_al !== ~e_seg || an_al !== ~e_an) begin
                errors++;
                $display("FAIL scan_al[%0d]: got seg=%h an=%b want %h %b",
                         i, seg_al, an_al, ~e_seg, ~e_an);
            end
            if (an == 3'b001 && seg == 8'h4F) lit_seen[0]++;
            if (an == 3'b010 && seg == 8'h5B) lit_seen[1]++;
            if (an == 3'b100 && seg == 8'h06) lit_seen[2]++;
        end
        checks++;
        if (lit_seen[0] == 0 || lit_seen[1] == 0 || lit_seen[2] == 0) begin
            errors++;
            $display("FAIL scan_digits: got slot counts %0d/%0d/%0d want all nonzero",
                     lit_seen[0], lit_seen[1], lit_seen[2]);
        end
    endtask

    task automatic test_blank();
        blank_lz = 1'b1;
        do_load(4'd0, 4'd0, 4'd7);
        for (int i = 0; i < 3 * SCAN_DIV; i++) begin
            tick();
            checks++;
            if (seg !== e_seg || an !== e_an) begin
                errors++;
                $display("FAIL blank_007[%0d]: got seg=%h an=%b want %h %b",
                         i, seg, an, e_seg, e_an);
            end
        end
        do_load(4'd0, 4'd4, 4'd0);
        for (int i = 0; i < 3 * SCAN_DIV; i++) begin
            tick();
            checks++;
            if (seg !== e_seg || an !== e_an) begin
                errors++;
                $display("FAIL blank_040[%0d]: got seg=%h an=%b want %h %b",
                         i, seg, an, e_seg, e_an);
            end
        end
    endtask

    task automatic test_err();
        blank_lz = 1'b1;
        do_load(4'hA, 4'd0, 4'd5);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: got err=%b want 1", err);
        end
        for (int i = 0; i < 3 * SCAN_DIV; i++) begin
            tick();
            checks++;
            if (seg !== e_seg || an !== e_an || err !== m_err) begin
                errors++;
                $display("FAIL err_disp[%0d]: got seg=%h an=%b err=%b want %h %b %b",
                         i, seg, an, err, e_seg, e_an, m_err);
            end
        end
        do_load(4'd2, 4'd5, 4'd5);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got err=%b want 0", err);
        end
    endtask

    task automatic test_blink();
        int guard;
        blank_lz = 1'b0;
        do_load(4'd1, 4'd2, 4'd3);
        blink_en = 1'b1;
        for (int i = 0; i < 3 * BLINK_DIV; i++) begin
            tick();
            checks++;
            if (seg !== e_seg || an !== e_an) begin
                errors++;
                $display("FAIL blink[%0d]: got seg=%h an=%b want %h %b",
                         i, seg, an, e_seg, e_an);
            end
        end
        // Walk into the middle of a dark window, then release blink.
        guard = 0;
        while (!(((k / BLINK_DIV) % 2 == 1) && (k % BLINK_DIV == 5)) && guard < 100) begin
            tick();
            guard++;
        end
        tick();
        checks++;
        if (an !== 3'b000 || seg !== 8'h00) begin
            errors++;
            $display("FAIL blink_dark: got seg=%h an=%b want 00 000", seg, an);
        end
        blink_en = 1'b0;
        tick();
        checks++;
        if (seg !== e_seg || an !== e_an || an === 3'b000) begin
            errors++;
            $display("FAIL blink_release: got seg=%h an=%b want %h %b", seg, an, e_seg, e_an);
        end
    endtask

    task automatic test_reset_mid();
        blank_lz = 1'b0; blink_en = 1'b0;
        do_load(4'd9, 4'd8, 4'hF);
        repeat (SCAN_DIV + 2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (seg !== 8'h00 || an !== 3'b000 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got seg=%h an=%b err=%b want 00 000 0", seg, an, err);
        end
        for (int i = 0; i < SCAN_DIV; i++) begin
            tick();
            checks++;
            if (seg !== 8'h3F || an !== 3'b001 || seg !== e_seg || an !== e_an) begin
                errors++;
                $display("FAIL reset_ones[%0d]: got seg=%h an=%b want 3f 001", i, seg, an);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            hundreds = 4'($urandom_range(0, 11));
            tens     = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            ones     = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) hundreds = 4'd0;
            load     = ($urandom_range(0, 4) == 0);
            blank_lz = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 9) == 0) blink_en = ~blink_en;
            rst      = ($urandom_range(0, 99) == 0);
            tick();
            checks++;
            if (seg !== e_seg || an !== e_an || err !== m_err) begin
                errors++;
                $display("FAIL random[%0d]: got seg=%h an=%b err=%b want %h %b %b",
                         i, seg, an, err, e_seg, e_an, m_err);
            end
            checks++;
            if (seg_al !== ~e_seg || an_al !== ~e_an || err_al !== m_err) begin
                errors++;
                $display("FAIL random_al[%0d]: got seg=%h an=%b err=%b want %h %b %b",
                         i, seg_al, an_al, err_al, ~e_seg, ~e_an, m_err);
            end
        end
        load = 1'b0; rst = 1'b0; blink_en = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_scan();
        test_blank();
        test_err();
        test_blink();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
